// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the program-counter sequencer.
// State encodings, default vectors and the jalr alignment mask live here.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10,
    TRAP = 2'b11
  } seq_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;
  localparam logic [31:0] ALIGN_MASK    = 32'hFFFF_FFFE;

  // Decoded control-flow bits for the instruction in flight
  typedef struct packed {
    logic is_branch;
    logic jumpbranch;
    logic is_jal;
    logic is_jalr;
  } br_dec_t;

  // jumpbranch only matters for conditional branches
  function automatic logic redirect_taken(input br_dec_t d);
    return (d.is_branch & d.jumpbranch) | d.is_jal | d.is_jalr;
  endfunction

endpackage

// File: rtl/pc_sequencer_target_calc.sv
// Combinational redirect target: pc+imm for branch/jal, (rs1+imm)&~1 for jalr.
// misaligned flags a target that is not on a 4-byte boundary.
module branch_target_calc
  import pc_sequencer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            is_jalr,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] sum;

  assign base       = is_jalr ? rs1_val : pc;
  assign sum        = base + imm;
  assign target     = is_jalr ? (sum & XLEN'(ALIGN_MASK)) : sum;
  // bit 0 is either masked (jalr) or ignored; bit 1 decides the trap
  assign misaligned = target[1];

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: holds the architectural PC, resolves branch/jal/jalr
// redirects, handles stall, halt/resume and misaligned-target traps, counts branches.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [31:0] TRAP_VEC  = DEF_TRAP_VEC,
  parameter int          XLEN      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            jumpbranch,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs1_val,
  input  logic            halt_req,
  input  logic            resume,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic            fetch_valid,
  output logic            flush,
  output logic            trap,
  output logic [31:0]     branch_count,
  output logic [31:0]     taken_count,
  output logic [1:0]      seq_state
);

  seq_state_e      state_q;
  br_dec_t         dec;
  logic            redirect;
  logic [XLEN-1:0] target;
  logic            misaligned;

  assign dec       = '{is_branch: is_branch, jumpbranch: jumpbranch,
                       is_jal: is_jal, is_jalr: is_jalr};
  assign redirect  = redirect_taken(dec);
  assign pc_plus4  = pc + XLEN'(4);
  assign seq_state = state_q;

  branch_target_calc #(.XLEN(XLEN)) u_target (
    .pc         (pc),
    .imm        (imm),
    .rs1_val    (rs1_val),
    .is_jalr    (is_jalr),
    .target     (target),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BOOT;
      pc           <= XLEN'(RESET_VEC);
      fetch_valid  <= 1'b0;
      flush        <= 1'b0;
      trap         <= 1'b0;
      branch_count <= '0;
      taken_count  <= '0;
    end else begin
      // flush/trap are single-cycle pulses unless re-armed below
      flush <= 1'b0;
      trap  <= 1'b0;
      unique case (state_q)
        BOOT: begin
          state_q     <= RUN;
          fetch_valid <= 1'b1;
        end
        TRAP: begin
          // TRAP_VEC is occupied by the trap cycle; fetch resumes after it
          state_q     <= RUN;
          fetch_valid <= 1'b1;
          pc          <= pc_plus4;
        end
        HALT: begin
          if (!halt_req && resume) begin
            state_q     <= RUN;
            fetch_valid <= 1'b1;
          end
        end
        RUN: begin
          if (halt_req) begin
            state_q     <= HALT;
            fetch_valid <= 1'b0;
          end else if (!stall) begin
            if (is_branch) begin
              branch_count <= branch_count + 32'd1;
              if (jumpbranch) taken_count <= taken_count + 32'd1;
            end
            if (redirect) begin
              flush <= 1'b1;
              if (misaligned) begin
                trap        <= 1'b1;
                state_q     <= TRAP;
                fetch_valid <= 1'b0;
                pc          <= XLEN'(TRAP_VEC);
              end else begin
                pc <= target;
              end
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        default: state_q <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table, a counter-wrap/reset sequence,
// then randomized stimulus checked against a cycle-level reference model.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        reset, stall, jumpbranch, is_branch, is_jal, is_jalr, halt_req, resume;
  logic [31:0] imm, rs1_val;
  logic [31:0] pc, pc_plus4, branch_count, taken_count;
  logic        fetch_valid, flush, trap;
  logic [1:0]  seq_state;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .jumpbranch(jumpbranch),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .imm(imm),
    .rs1_val(rs1_val), .halt_req(halt_req), .resume(resume), .pc(pc),
    .pc_plus4(pc_plus4), .fetch_valid(fetch_valid), .flush(flush), .trap(trap),
    .branch_count(branch_count), .taken_count(taken_count), .seq_state(seq_state)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [1:0]  st;
    logic        fv;
    logic        fl;
    logic        tr;
    logic [31:0] bc;
    logic [31:0] tc;
  } obs_t;

  typedef struct {
    logic        rst, stl, br, jb, jal, jalr, hr, rs;
    logic [31:0] imm, rs1;
    obs_t        exp;
  } vec_t;

  // Reference model: architectural view of the sequencer
  logic [1:0]  m_st;
  logic [31:0] m_pc, m_bc, m_tc;
  logic        m_fl, m_tr;

  task automatic model_edge();
    logic [31:0] tgt;
    logic        redir;
    if (reset) begin
      m_st = 2'd0; m_pc = 32'h0; m_fl = 0; m_tr = 0; m_bc = 0; m_tc = 0;
      return;
    end
    m_fl = 0; m_tr = 0;
    if (m_st == 2'd0) m_st = 2'd1;
    else if (m_st == 2'd3) begin m_st = 2'd1; m_pc = m_pc + 4; end
    else if (m_st == 2'd2) begin if (!halt_req && resume) m_st = 2'd1; end
    else if (halt_req) m_st = 2'd2;
    else if (!stall) begin
      if (is_branch) begin m_bc = m_bc + 1; if (jumpbranch) m_tc = m_tc + 1; end
      redir = is_jalr || is_jal || (is_branch && jumpbranch);
      tgt   = is_jalr ? ((rs1_val + imm) & ~32'd1) : (m_pc + imm);
      if (!redir) m_pc = m_pc + 4;
      else if (tgt[1]) begin m_st = 2'd3; m_pc = 32'h100; m_fl = 1; m_tr = 1; end
      else begin m_pc = tgt; m_fl = 1; end
    end
  endtask

  function automatic obs_t model_obs();
    return '{pc: m_pc, pc4: m_pc + 32'd4, st: m_st, fv: (m_st == 2'd1),
             fl: m_fl, tr: m_tr, bc: m_bc, tc: m_tc};
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = '{pc: pc, pc4: pc_plus4, st: seq_state, fv: fetch_valid, fl: flush,
            tr: trap, bc: branch_count, tc: taken_count};
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got pc=%h pc4=%h st=%0d fv=%b fl=%b tr=%b bc=%h tc=%h ; want pc=%h pc4=%h st=%0d fv=%b fl=%b tr=%b bc=%h tc=%h",
               name, act.pc, act.pc4, act.st, act.fv, act.fl, act.tr, act.bc, act.tc,
               exp.pc, exp.pc4, exp.st, exp.fv, exp.fl, exp.tr, exp.bc, exp.tc);
    end
  endtask

  task automatic drive(input logic r, s, br, jb, jal, jalr, hr, rs,
                       input logic [31:0] im, r1);
    reset = r; stall = s; is_branch = br; jumpbranch = jb; is_jal = jal;
    is_jalr = jalr; halt_req = hr; resume = rs; imm = im; rs1_val = r1;
  endtask

  // Apply current inputs across one edge, then sample 1ns later
  task automatic edge_step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic r, s, br, jb, jal, jalr, hr, rs,
                              input logic [31:0] im, r1, e_pc,
                              input logic [1:0] e_st, input logic e_fl, e_tr,
                              input logic [31:0] e_bc, e_tc);
    vec_t v;
    v.rst = r; v.stl = s; v.br = br; v.jb = jb; v.jal = jal; v.jalr = jalr;
    v.hr = hr; v.rs = rs; v.imm = im; v.rs1 = r1;
    v.exp = '{pc: e_pc, pc4: e_pc + 32'd4, st: e_st, fv: (e_st == 2'd1),
              fl: e_fl, tr: e_tr, bc: e_bc, tc: e_tc};
    return v;
  endfunction

  vec_t vecs[26];

  initial begin
    //          rst stl br jb jal jalr hr rs  imm            rs1         pc        st fl tr bc tc
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   2'd0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   2'd1, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h4,   2'd1, 0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h8,   2'd1, 0, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'hC,   2'd1, 0, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h10,  2'd1, 0, 0, 0, 0);
    vecs[6]  = mk(0, 0, 1, 1, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,  32'h8,   2'd1, 1, 0, 1, 1);
    vecs[7]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 32'hFFFF_FFF8, 32'h0,  32'hC,   2'd1, 0, 0, 2, 1);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h203, 32'h100, 2'd3, 1, 1, 2, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h104, 2'd1, 0, 0, 2, 1);
    vecs[10] = mk(0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FF1C, 32'h0,  32'h20,  2'd1, 1, 0, 2, 1);
    vecs[11] = mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h40,       32'h0,   32'h20,  2'd1, 0, 0, 2, 1);
    vecs[12] = mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h40,       32'h0,   32'h20,  2'd1, 0, 0, 2, 1);
    vecs[13] = mk(0, 1, 0, 0, 1, 0, 0, 0, 32'h40,       32'h0,   32'h20,  2'd1, 0, 0, 2, 1);
    vecs[14] = mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h40,       32'h0,   32'h60,  2'd1, 1, 0, 2, 1);
    vecs[15] = mk(0, 0, 0, 0, 1, 0, 0, 0, 32'hFFFF_FFD0, 32'h0,  32'h30,  2'd1, 1, 0, 2, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 1, 1, 32'h0,        32'h0,   32'h30,  2'd2, 0, 0, 2, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 1, 32'h0,        32'h0,   32'h30,  2'd1, 0, 0, 2, 1);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h34,  2'd1, 0, 0, 2, 1);
    vecs[19] = mk(0, 0, 0, 0, 0, 0, 1, 0, 32'h0,        32'h0,   32'h34,  2'd2, 0, 0, 2, 1);
    vecs[20] = mk(0, 0, 0, 0, 1, 0, 0, 0, 32'h100,      32'h0,   32'h34,  2'd2, 0, 0, 2, 1);
    vecs[21] = mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   2'd0, 0, 0, 0, 0);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0,        32'h0,   32'h0,   2'd1, 0, 0, 0, 0);
    vecs[23] = mk(0, 0, 0, 0, 0, 1, 0, 0, 32'h0,        32'h85,  32'h84,  2'd1, 1, 0, 0, 0);
    vecs[24] = mk(0, 0, 0, 1, 0, 0, 0, 0, 32'h40,       32'h0,   32'h88,  2'd1, 0, 0, 0, 0);
    vecs[25] = mk(0, 0, 0, 0, 1, 1, 0, 0, 32'h4,        32'h200, 32'h204, 2'd1, 1, 0, 0, 0);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    m_st = 2'd0; m_pc = 0; m_bc = 0; m_tc = 0; m_fl = 0; m_tr = 0;
    #1;

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].rst, vecs[i].stl, vecs[i].br, vecs[i].jb, vecs[i].jal,
            vecs[i].jalr, vecs[i].hr, vecs[i].rs, vecs[i].imm, vecs[i].rs1);
      edge_step();
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Counter wrap: preload both counters at all-ones, then retire a taken branch
    force dut.branch_count = 32'hFFFF_FFFF;
    force dut.taken_count  = 32'hFFFF_FFFF;
    #1;
    release dut.branch_count;
    release dut.taken_count;
    m_bc = 32'hFFFF_FFFF; m_tc = 32'hFFFF_FFFF;
    drive(0, 0, 1, 1, 0, 0, 0, 0, 32'h8, 32'h0);
    edge_step();
    check("wrap", '{pc: 32'h20C, pc4: 32'h210, st: 2'd1, fv: 1'b1, fl: 1'b1,
                    tr: 1'b0, bc: 32'h0, tc: 32'h0});
    drive(0, 0, 1, 1, 0, 0, 1, 0, 32'h8, 32'h0);
    edge_step();
    check("halt_no_count", '{pc: 32'h20C, pc4: 32'h210, st: 2'd2, fv: 1'b0, fl: 1'b0,
                             tr: 1'b0, bc: 32'h0, tc: 32'h0});
    drive(0, 0, 1, 1, 0, 0, 0, 0, 32'h8, 32'h0);
    edge_step();
    check("halt_hold", model_obs());
    drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0);
    edge_step();
    check("reset_in_halt", '{pc: 32'h0, pc4: 32'h4, st: 2'd0, fv: 1'b0, fl: 1'b0,
                             tr: 1'b0, bc: 32'h0, tc: 32'h0});

    // Randomized run against the model
    for (int i = 0; i < 1500; i++) begin
      logic [31:0] r;
      r = $urandom_range(0, 255);
      drive($urandom_range(0, 199) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
            $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
            (r - 32'd128) << 1, 32'($urandom_range(0, 1023)));
      edge_step();
      check($sformatf("rand%0d", i), model_obs());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
